// File: rtl/dae_sequencer.sv
// dae_sequencer: micro-sequencer owning a small register file and driving the shared 4-bit ALU.
// Latency: accept at edge N, ALU result captured at N+1, register written (visible on dbg_data) at N+2.
// Backpressure: instr_ready is high only in IDLE, so one instruction completes every 3 cycles.
// Optional macro DAE_SEQ_ZERO_FLAG_EN adds zero_flag, which is updated at each write-back edge.
module dae_sequencer #(
  parameter int DATA_W = 4,
  parameter int ADDR_W = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    instr_valid,
  output logic                    instr_ready,
  input  logic [3+3*ADDR_W:0]     instr,
  output logic [2:0]              alu_sel,
  output logic [DATA_W-1:0]       alu_a,
  output logic [DATA_W-1:0]       alu_b,
  input  logic [DATA_W-1:0]       alu_y,
  output logic                    wb_valid,
  output logic [ADDR_W-1:0]       wb_addr,
  output logic [DATA_W-1:0]       wb_data,
  input  logic [ADDR_W-1:0]       dbg_addr,
  output logic [DATA_W-1:0]       dbg_data
`ifdef DAE_SEQ_ZERO_FLAG_EN
  ,
  output logic                    zero_flag
`endif
);

  localparam int INSTR_W = 4 + 3*ADDR_W;
  localparam int NREGS   = 2**ADDR_W;

  typedef enum logic [1:0] {IDLE, EXEC, WB} state_t;

  state_t state, state_nxt;

  logic [DATA_W-1:0] regs [NREGS];

  // Instruction fields: {ld, op, rd_idx, rs_idx, rt_idx}
  logic              f_ld;
  logic [2:0]        f_op;
  logic [ADDR_W-1:0] f_rd, f_rs, f_rt;
  logic              accept;

  // Latched per-instruction context
  logic              ld_q;
  logic [ADDR_W-1:0] rd_q;
  logic [DATA_W-1:0] imm_q;

  assign f_ld   = instr[INSTR_W-1];
  assign f_op   = instr[INSTR_W-2 -: 3];
  assign f_rd   = instr[3*ADDR_W-1 -: ADDR_W];
  assign f_rs   = instr[2*ADDR_W-1 -: ADDR_W];
  assign f_rt   = instr[ADDR_W-1:0];
  assign accept = instr_valid && instr_ready;

  assign dbg_data = regs[dbg_addr];

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state and handshake: a fixed IDLE -> EXEC -> WB -> IDLE walk per accepted instruction
  always_comb begin
    state_nxt   = state;
    instr_ready = 1'b0;
    case (state)
      IDLE: begin
        instr_ready = 1'b1;
        if (instr_valid) state_nxt = EXEC;
      end
      EXEC:    state_nxt = WB;
      WB:      state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Operand capture on accept (pre-write values), then result capture at the end of EXEC
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ld_q     <= 1'b0;
      rd_q     <= '0;
      imm_q    <= '0;
      alu_sel  <= '0;
      alu_a    <= '0;
      alu_b    <= '0;
      wb_valid <= 1'b0;
      wb_addr  <= '0;
      wb_data  <= '0;
    end else begin
      if (accept) begin
        ld_q    <= f_ld;
        rd_q    <= f_rd;
        imm_q   <= {f_rs, f_rt};
        alu_sel <= f_op;
        alu_a   <= regs[f_rs];
        alu_b   <= regs[f_rt];
      end
      if (state == EXEC) begin
        wb_valid <= 1'b1;
        wb_addr  <= rd_q;
        wb_data  <= ld_q ? imm_q : alu_y;
      end else begin
        wb_valid <= 1'b0;
      end
    end
  end

  // Register file: written on the edge that ends WB, so dbg_data shows the old value during WB
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (state == WB) begin
      regs[wb_addr] <= wb_data;
    end
  end

`ifdef DAE_SEQ_ZERO_FLAG_EN
  // Zero flag tracks the most recent write-back value
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)             zero_flag <= 1'b0;
    else if (state == WB)   zero_flag <= (wb_data == '0);
  end
`endif

endmodule

// File: tb/tb_dae_sequencer.sv
// tb_dae_sequencer: self-checking bench for dae_sequencer with a behavioural ALU and register model.
// Table vectors for directed cases, hand sequences for hold/reset corners, then random instructions.
// Summary line reports comparisons run and failed.
module tb_dae_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       instr_valid;
  logic       instr_ready;
  logic [9:0] instr;
  logic [2:0] alu_sel;
  logic [3:0] alu_a, alu_b, alu_y;
  logic       wb_valid;
  logic [1:0] wb_addr;
  logic [3:0] wb_data;
  logic [1:0] dbg_addr;
  logic [3:0] dbg_data;
`ifdef DAE_SEQ_ZERO_FLAG_EN
  logic       zero_flag;
`endif

  int n_tests = 0;
  int n_fail  = 0;
  int m [4];

  dae_sequencer dut (
    .clk(clk), .rst_n(rst_n),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr),
    .alu_sel(alu_sel), .alu_a(alu_a), .alu_b(alu_b), .alu_y(alu_y),
    .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data)
`ifdef DAE_SEQ_ZERO_FLAG_EN
    , .zero_flag(zero_flag)
`endif
  );

  always #5 clk = ~clk;

  // Reference ALU in plain arithmetic; also stands in for the real ALU instance
  function automatic logic [3:0] alu_ref(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b);
    int ia, ib, r;
    ia = int'(a);
    ib = int'(b);
    case (op)
      3'd0: r = (ia - ib + 16) % 16;
      3'd1: r = (ia + ib) % 16;
      3'd2: r = ia | ib;
      3'd3: r = ia & ib;
      3'd4: r = ib / 2 + ((ib >= 8) ? 8 : 0);
      3'd5: r = (ia * 2) % 16 + ia / 8;
      3'd6: r = 10 + ((ia < ib) ? 1 : 0);
      default: r = 14 + ((ia == ib) ? 1 : 0);
    endcase
    return r[3:0];
  endfunction

  always_comb alu_y = alu_ref(alu_sel, alu_a, alu_b);

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Drives one instruction from IDLE through WB back to IDLE, returning observations
  task automatic do_instr(input logic [9:0] ins,
                          output logic [2:0] o_sel, output logic [3:0] o_a, output logic [3:0] o_b,
                          output logic o_wv, output logic [1:0] o_wa, output logic [3:0] o_wd,
                          output logic [3:0] o_old, output logic o_wv2, output logic o_hold);
    chk("ready_idle", instr_ready, 1'b1);
    instr = ins;
    instr_valid = 1'b1;
    @(posedge clk); #1;
    instr_valid = 1'b0;
    instr = 10'($urandom_range(0, 1023));
    chk("ready_exec", instr_ready, 1'b0);
    o_sel = alu_sel; o_a = alu_a; o_b = alu_b;
    chk("no_wb_exec", wb_valid, 1'b0);
    dbg_addr = ins[5:4];
    @(posedge clk); #1;
    o_wv = wb_valid; o_wa = wb_addr; o_wd = wb_data; o_old = dbg_data;
    @(posedge clk); #1;
    o_wv2  = wb_valid;
    o_hold = (alu_sel == o_sel) && (alu_a == o_a) && (alu_b == o_b);
  endtask

  task automatic chk_all_regs(input string nm);
    for (int i = 0; i < 4; i++) begin
      dbg_addr = 2'(i);
      #1;
      chk(nm, dbg_data, m[i][3:0]);
    end
  endtask

  typedef struct {
    logic [9:0] ins;
    logic [2:0] sel;
    logic [3:0] a;
    logic [3:0] b;
    logic [1:0] wa;
    logic [3:0] wd;
  } vec_t;

  vec_t vt [7];

  initial begin
    logic [2:0] s;
    logic [3:0] a, b, wd, old, res;
    logic [1:0] wa;
    logic       wv, wv2, hold;
    int acc, wbc, first_wb, last_wb, rdy_low;

    // {ins = {ld,op,rd,rs,rt}, sel, a, b, wb_addr, wb_data}
    vt[0] = '{10'b1_000_01_01_01, 3'd0, 4'd0, 4'd0, 2'd1, 4'h5}; // LI r1,5
    vt[1] = '{10'b1_000_10_00_11, 3'd0, 4'd0, 4'd0, 2'd2, 4'h3}; // LI r2,3
    vt[2] = '{10'b0_001_11_01_10, 3'd1, 4'd5, 4'd3, 2'd3, 4'h8}; // ADD r3,r1,r2
    vt[3] = '{10'b0_000_00_10_01, 3'd0, 4'd3, 4'd5, 2'd0, 4'hE}; // SUB r0,r2,r1
    vt[4] = '{10'b0_111_00_01_01, 3'd7, 4'd5, 4'd5, 2'd0, 4'hF}; // EQ r0,r1,r1
    vt[5] = '{10'b0_110_00_10_01, 3'd6, 4'd3, 4'd5, 2'd0, 4'hB}; // LT r0,r2,r1
    vt[6] = '{10'b0_001_01_01_01, 3'd1, 4'd5, 4'd5, 2'd1, 4'hA}; // ADD r1,r1,r1

    for (int i = 0; i < 4; i++) m[i] = 0;
    rst_n = 1'b0; instr_valid = 1'b0; instr = '0; dbg_addr = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_wb_valid", wb_valid, 1'b0);
    chk("rst_wb_addr", wb_addr, 2'd0);
    chk("rst_wb_data", wb_data, 4'd0);
    chk("rst_alu_sel", alu_sel, 3'd0);
    chk("rst_alu_a", alu_a, 4'd0);
    chk("rst_alu_b", alu_b, 4'd0);
    chk_all_regs("rst_dbg");
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    chk("ready_after_rst", instr_ready, 1'b1);

    // Directed vectors
    for (int i = 0; i < 7; i++) begin
      do_instr(vt[i].ins, s, a, b, wv, wa, wd, old, wv2, hold);
      chk("vec_sel", s, vt[i].sel);
      chk("vec_a", a, vt[i].a);
      chk("vec_b", b, vt[i].b);
      chk("vec_wv", wv, 1'b1);
      chk("vec_wa", wa, vt[i].wa);
      chk("vec_wd", wd, vt[i].wd);
      chk("vec_dbg_old", old, m[vt[i].wa][3:0]);
      chk("vec_wv_pulse", wv2, 1'b0);
      chk("vec_alu_hold", hold, 1'b1);
      m[vt[i].wa] = int'(vt[i].wd);
      dbg_addr = vt[i].wa; #1;
      chk("vec_dbg_new", dbg_data, vt[i].wd);
`ifdef DAE_SEQ_ZERO_FLAG_EN
      chk("vec_zero_flag", zero_flag, vt[i].wd == 4'd0);
`endif
    end

    // instr_valid held for 6 cycles: two accepts, wb pulses 3 cycles apart
    acc = 0; wbc = 0; first_wb = -1; last_wb = -1; rdy_low = 0;
    instr = 10'b1_000_10_01_11; // LI r2,7
    instr_valid = 1'b1;
    for (int c = 0; c < 6; c++) begin
      if (instr_ready) acc++; else rdy_low++;
      if (wb_valid) begin
        wbc++;
        if (first_wb < 0) first_wb = c;
        last_wb = c;
      end
      @(posedge clk); #1;
    end
    instr_valid = 1'b0;
    chk("hold_accepts", acc, 2);
    chk("hold_ready_low", rdy_low, 4);
    chk("hold_wb_count", wbc, 2);
    chk("hold_wb_gap", last_wb - first_wb, 3);
    m[2] = 7;
    chk_all_regs("hold_regs");

    // Reset asserted during EXEC of ADD r3,r1,r2
    instr = 10'b0_001_11_01_10;
    instr_valid = 1'b1;
    @(posedge clk); #1;
    instr_valid = 1'b0;
    chk("rmid_exec_sel", alu_sel, 3'd1);
    rst_n = 1'b0;
    #1;
    for (int i = 0; i < 4; i++) m[i] = 0;
    chk("rmid_wb_valid", wb_valid, 1'b0);
    chk("rmid_alu_a", alu_a, 4'd0);
    chk("rmid_alu_b", alu_b, 4'd0);
    chk("rmid_ready", instr_ready, 1'b1);
`ifdef DAE_SEQ_ZERO_FLAG_EN
    chk("rmid_zero_flag", zero_flag, 1'b0);
`endif
    chk_all_regs("rmid_regs");
    @(negedge clk) rst_n = 1'b1;
    wbc = 0;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      if (wb_valid) wbc++;
    end
    chk("rmid_no_wb", wbc, 0);
    chk("rmid_ready_after", instr_ready, 1'b1);

    // Random instructions against the register model, with random idle gaps
    for (int n = 0; n < 60; n++) begin
      logic [9:0] ri;
      ri = 10'($urandom_range(0, 1023));
      if (ri[9]) res = {ri[3:2], ri[1:0]};
      else       res = alu_ref(ri[8:6], m[ri[3:2]][3:0], m[ri[1:0]][3:0]);
      do_instr(ri, s, a, b, wv, wa, wd, old, wv2, hold);
      chk("rnd_sel", s, ri[8:6]);
      chk("rnd_a", a, m[ri[3:2]][3:0]);
      chk("rnd_b", b, m[ri[1:0]][3:0]);
      chk("rnd_wv", wv, 1'b1);
      chk("rnd_wa", wa, ri[5:4]);
      chk("rnd_wd", wd, res);
      chk("rnd_dbg_old", old, m[ri[5:4]][3:0]);
      chk("rnd_wv_pulse", wv2, 1'b0);
      m[ri[5:4]] = int'(res);
`ifdef DAE_SEQ_ZERO_FLAG_EN
      chk("rnd_zero_flag", zero_flag, res == 4'd0);
`endif
      dbg_addr = 2'($urandom_range(0, 3)); #1;
      chk("rnd_dbg", dbg_data, m[dbg_addr][3:0]);
      repeat ($urandom_range(0, 2)) begin
        instr = 10'($urandom_range(0, 1023));
        @(posedge clk); #1;
        chk("rnd_idle_no_wb", wb_valid, 1'b0);
      end
    end
    chk_all_regs("final_regs");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1, "timeout");
  end

endmodule
